// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between the MEM stage and the data memory
interface data_memory_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        valid;
   logic [31:0] rdata;
   logic        err;
   modport master (output req, we, size, uns, addr, wdata, input ready, valid, rdata, err);
   modport slave (input req, we, size, uns, addr, wdata, output ready, valid, rdata, err);
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory with configurable response latency
module data_memory_ctrl #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 1
) (
   input logic              clk_i,
   input logic              rst_i,
   data_memory_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH_BYTES);
   localparam int CW = $clog2(LATENCY + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            h_we, h_uns;
   logic [1:0]      h_size;
   logic [31:0]     h_addr, h_data;
   logic [7:0]      mem [DEPTH_BYTES];
   logic            accept, commit, from_hold, c_we, c_uns, c_err;
   logic [1:0]      c_size;
   logic [31:0]     c_addr, c_data, ld;
   logic [AW-1:0]   a0, a1, a2, a3;
   logic [7:0]      b0, b1, b2, b3;
   assign accept = bus.req && bus.ready;
   assign commit = rst_i && state_nx == DONE;
   // with LATENCY=1 the commit edge is also the accept edge, so operands come straight from the bus
   always_comb begin
      from_hold = state == BUSY;
      c_we   = from_hold ? h_we   : bus.we;
      c_uns  = from_hold ? h_uns  : bus.uns;
      c_size = from_hold ? h_size : bus.size;
      c_addr = from_hold ? h_addr : bus.addr;
      c_data = from_hold ? h_data : bus.wdata;
      c_err  = c_size == 2'b11 || (c_size == 2'b01 && c_addr[0]) ||
               (c_size == 2'b10 && c_addr[1:0] != 2'b00) || c_addr[31:AW] != '0;
      a0 = c_addr[AW-1:0];
      a1 = a0 + AW'(1);
      a2 = a0 + AW'(2);
      a3 = a0 + AW'(3);
      b0 = mem[a0];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];
      ld = c_size == 2'b00 ? {{24{b0[7] & ~c_uns}}, b0} :
           c_size == 2'b01 ? {{16{b1[7] & ~c_uns}}, b1, b0} : {b3, b2, b1, b0};
   end
   // state register, latency counter and response registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         bus.rdata <= '0;
         bus.err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= accept ? CW'(LATENCY - 1) : state == BUSY ? cnt - CW'(1) : cnt;
         if (commit) begin
            bus.rdata <= (c_err || c_we) ? '0 : ld;
            bus.err   <= c_err;
         end
      end
   end
   // next state: BUSY counts down to DONE; IDLE and DONE both accept new requests
   always_comb begin
      state_nx = state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) :
                 accept ? (LATENCY == 1 ? DONE : BUSY) : IDLE;
   end
   // handshake outputs decoded from state
   always_comb begin
      bus.ready = state != BUSY;
      bus.valid = state == DONE;
   end
   // capture the request so later bus activity cannot disturb it
   always_ff @(posedge clk_i) begin
      if (accept) begin
         h_we   <= bus.we;
         h_uns  <= bus.uns;
         h_size <= bus.size;
         h_addr <= bus.addr;
         h_data <= bus.wdata;
      end
   end
   // store lanes, little-endian, skipped on any error
   always_ff @(posedge clk_i) begin
      if (commit && c_we && !c_err) begin
         mem[a0] <= c_data[7:0];
         if (c_size != 2'b00) mem[a1] <= c_data[15:8];
         if (c_size == 2'b10) begin
            mem[a2] <= c_data[23:16];
            mem[a3] <= c_data[31:24];
         end
      end
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench covering latency 1, 3 and 4 configurations
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   logic rst3 = 1'b1, rst1 = 1'b1, rst4 = 1'b1;
   int checks = 0, errors = 0;
   logic [32:0] q3[$], q1[$], q4[$];
   logic [32:0] e3, e1, e4;
   data_memory_ctrl_if b3 ();
   data_memory_ctrl_if b1 ();
   data_memory_ctrl_if b4 ();
   data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(3)) u3 (.clk_i(clk), .rst_i(rst3), .bus(b3));
   data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst1), .bus(b1));
   data_memory_ctrl #(.DEPTH_BYTES(1024), .LATENCY(4)) u4 (.clk_i(clk), .rst_i(rst4), .bus(b4));
   always #5 clk = ~clk;
   // scoreboard monitors: every response strobe must match the oldest expected result
   always @(negedge clk) begin
      if (b3.valid === 1'b1) begin
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL mon3 unexpected valid err=%b data=%h", b3.err, b3.rdata);
         end else begin
            e3 = q3.pop_front();
            if ({b3.err, b3.rdata} !== e3) begin
               errors++;
               $display("FAIL mon3 got err/data %h want %h", {b3.err, b3.rdata}, e3);
            end
         end
      end
   end
   always @(negedge clk) begin
      if (b1.valid === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1 unexpected valid err=%b data=%h", b1.err, b1.rdata);
         end else begin
            e1 = q1.pop_front();
            if ({b1.err, b1.rdata} !== e1) begin
               errors++;
               $display("FAIL mon1 got err/data %h want %h", {b1.err, b1.rdata}, e1);
            end
         end
      end
   end
   always @(negedge clk) begin
      if (b4.valid === 1'b1) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL mon4 unexpected valid err=%b data=%h", b4.err, b4.rdata);
         end else begin
            e4 = q4.pop_front();
            if ({b4.err, b4.rdata} !== e4) begin
               errors++;
               $display("FAIL mon4 got err/data %h want %h", {b4.err, b4.rdata}, e4);
            end
         end
      end
   end
   task automatic send3(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [32:0] exp);
      int n = 0;
      b3.req = 1'b1; b3.we = w; b3.size = sz; b3.uns = u; b3.addr = a; b3.wdata = d;
      q3.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      b3.req = 1'b0;
      while (b3.valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (b3.valid !== 1'b1) begin
         errors++;
         $display("FAIL send3_timeout addr=%h valid=%b want 1", a, b3.valid);
      end
   endtask
   task automatic send4(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [32:0] exp);
      int n = 0;
      b4.req = 1'b1; b4.we = w; b4.size = sz; b4.uns = u; b4.addr = a; b4.wdata = d;
      q4.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      b4.req = 1'b0;
      while (b4.valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (b4.valid !== 1'b1) begin
         errors++;
         $display("FAIL send4_timeout addr=%h valid=%b want 1", a, b4.valid);
      end
   endtask
   task automatic test_reset;
      #2 rst3 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
      repeat (3) @(negedge clk);
      rst3 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
      @(negedge clk);
      checks++;
      if ({b3.ready, b3.valid, b3.err, b3.rdata} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL reset3 got %b %b %b %h want 1 0 0 0", b3.ready, b3.valid, b3.err, b3.rdata);
      end
      checks++;
      if ({b1.ready, b1.valid, b1.err, b1.rdata} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL reset1 got %b %b %b %h want 1 0 0 0", b1.ready, b1.valid, b1.err, b1.rdata);
      end
      checks++;
      if ({b4.ready, b4.valid, b4.err, b4.rdata} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL reset4 got %b %b %b %h want 1 0 0 0", b4.ready, b4.valid, b4.err, b4.rdata);
      end
   endtask
   task automatic test_latency;
      b3.req = 1'b1; b3.we = 1'b1; b3.size = 2'b10; b3.uns = 1'b0; b3.addr = 32'h10; b3.wdata = 32'h12345678;
      q3.push_back(33'h0);
      @(posedge clk);
      @(negedge clk);
      b3.req = 1'b0;
      checks++;
      if ({b3.valid, b3.ready} !== 2'b00) begin
         errors++;
         $display("FAIL lat_e0 valid/ready got %b%b want 00", b3.valid, b3.ready);
      end
      @(negedge clk);
      checks++;
      if (b3.valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_e1 valid got %b want 0", b3.valid);
      end
      @(negedge clk);
      checks++;
      if ({b3.valid, b3.ready} !== 2'b11) begin
         errors++;
         $display("FAIL lat_e2 valid/ready got %b%b want 11", b3.valid, b3.ready);
      end
      @(negedge clk);
      checks++;
      if ({b3.valid, b3.ready} !== 2'b01) begin
         errors++;
         $display("FAIL lat_e3 valid/ready got %b%b want 01", b3.valid, b3.ready);
      end
      send3(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'h12345678});
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({b3.valid, b3.err, b3.rdata} !== {2'b00, 32'h12345678}) begin
         errors++;
         $display("FAIL hold got %b %b %h want 0 0 12345678", b3.valid, b3.err, b3.rdata);
      end
   endtask
   task automatic test_extend;
      send3(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, {1'b0, 32'h00000056});
      send3(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, {1'b0, 32'h00001234});
      send3(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 33'h0);
      send3(1'b1, 2'b00, 1'b0, 32'h20, 32'hAABBCC80, 33'h0);
      send3(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, {1'b0, 32'hFFFFFF80});
      send3(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, {1'b0, 32'h00000080});
      send3(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 33'h0);
      send3(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, {1'b0, 32'hBEEF0080});
      send3(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, {1'b0, 32'hFFFFBEEF});
   endtask
   task automatic test_errors;
      send3(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'h12345678});
      send3(1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFFFF, {1'b1, 32'h0});
      send3(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, {1'b1, 32'h0});
      send3(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, {1'b1, 32'h0});
      send3(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, {1'b1, 32'h0});
      send3(1'b1, 2'b00, 1'b0, 32'h410, 32'h0, {1'b1, 32'h0});
      send3(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'h12345678});
   endtask
   task automatic test_ignore_busy;
      int n = 0;
      @(negedge clk);
      b3.req = 1'b1; b3.we = 1'b0; b3.size = 2'b10; b3.addr = 32'h10;
      q3.push_back({1'b0, 32'h12345678});
      @(posedge clk);
      @(negedge clk);
      b3.we = 1'b1; b3.wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      b3.req = 1'b0; b3.we = 1'b0;
      while (b3.valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (b3.valid !== 1'b1) begin
         errors++;
         $display("FAIL busy_timeout valid got %b want 1", b3.valid);
      end
      repeat (5) @(negedge clk);
      send3(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'h12345678});
   endtask
   task automatic test_back_to_back;
      logic        w[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
      logic [1:0]  sz[8] = '{2, 2, 2, 2, 2, 0, 1, 1};
      logic        u[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
      logic [31:0] a[8]  = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h40, 32'h44, 32'h4A, 32'h48};
      logic [31:0] d[8]  = '{32'h01020304, 32'h000000F1, 32'hA5B6C7D8, 32'h0, 0, 0, 0, 0};
      logic [31:0] x[8]  = '{0, 0, 0, 0, 32'h01020304, 32'hFFFFFFF1, 32'h0000A5B6, 32'hFFFFC7D8};
      @(negedge clk);
      b1.req = 1'b1; b1.we = w[0]; b1.size = sz[0]; b1.uns = u[0]; b1.addr = a[0]; b1.wdata = d[0];
      q1.push_back({1'b0, x[0]});
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({b1.ready, b1.valid} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_%0d ready/valid got %b%b want 11", k, b1.ready, b1.valid);
         end
         if (k < 7) begin
            b1.we = w[k+1]; b1.size = sz[k+1]; b1.uns = u[k+1]; b1.addr = a[k+1]; b1.wdata = d[k+1];
            q1.push_back({1'b0, x[k+1]});
         end else b1.req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({b1.ready, b1.valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_end ready/valid got %b%b want 10", b1.ready, b1.valid);
      end
   endtask
   task automatic test_reset_busy;
      logic seen = 1'b0;
      send4(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 33'h0);
      send4(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, {1'b0, 32'h11223344});
      b4.req = 1'b1; b4.we = 1'b1; b4.size = 2'b10; b4.addr = 32'h30; b4.wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      b4.req = 1'b0; b4.we = 1'b0;
      checks++;
      if (b4.ready !== 1'b0) begin
         errors++;
         $display("FAIL rstb_busy ready got %b want 0", b4.ready);
      end
      #2 rst4 = 1'b0;
      #1;
      checks++;
      if ({b4.ready, b4.valid, b4.err, b4.rdata} !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL rstb_async got %b %b %b %h want 1 0 0 0", b4.ready, b4.valid, b4.err, b4.rdata);
      end
      @(negedge clk);
      rst4 = 1'b1;
      repeat (6) begin
         @(negedge clk);
         seen = seen | (b4.valid !== 1'b0);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rstb_novalid valid seen=%b want 0", seen);
      end
      send4(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, {1'b0, 32'h11223344});
   endtask
   initial begin
      b3.req = 0; b3.we = 0; b3.size = 0; b3.uns = 0; b3.addr = 0; b3.wdata = 0;
      b1.req = 0; b1.we = 0; b1.size = 0; b1.uns = 0; b1.addr = 0; b1.wdata = 0;
      b4.req = 0; b4.we = 0; b4.size = 0; b4.uns = 0; b4.addr = 0; b4.wdata = 0;
      test_reset();
      test_latency();
      test_extend();
      test_errors();
      test_ignore_busy();
      test_back_to_back();
      test_reset_busy();
      repeat (3) @(negedge clk);
      checks++;
      if (q3.size() + q1.size() + q4.size() != 0) begin
         errors++;
         $display("FAIL sb_drain left %0d/%0d/%0d want 0", q3.size(), q1.size(), q4.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
